// File: rtl/rv_branch_unit.sv
// rv_branch_unit: execute-stage branch resolution with a bimodal predictor.
// Resolves the six RV conditional branches, computes the corrected next PC,
// flags mispredicts and illegal conditions one cycle later, trains a table of
// 2-bit saturating counters and keeps saturating branch/mispredict statistics.
module rv_branch_unit #(
  parameter int XLEN      = 64,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic             pred_taken_i,
  input  logic             flush_i,
  input  logic [XLEN-1:0]  fetch_pc_i,
  output logic             pred_taken_o,
  output logic             resolve_valid_o,
  output logic             taken_o,
  output logic             mispredict_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [XLEN-1:0]  PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Next state of a 2-bit saturating predictor counter.
  function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
    return res;
  endfunction

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             fetch_pc_unused;

  logic             cond_taken;
  logic             cond_legal;
  logic             is_eq;
  logic             is_lt;
  logic             is_ltu;
  logic             accept;
  logic             illegal_accept;
  logic             mispredict;
  logic [XLEN-1:0]  target_pc;
  logic [XLEN-1:0]  seq_pc;

  assign fetch_idx       = fetch_pc_i[IDX_W+1:2];
  assign upd_idx         = pc_i[IDX_W+1:2];
  assign fetch_pc_unused = ^{fetch_pc_i[XLEN-1:IDX_W+2], fetch_pc_i[1:0]};

  // The prediction reads the pre-update table, so a same-cycle write shows up next cycle.
  assign pred_taken_o = bht[fetch_idx][1];

  assign is_eq  = (rs1_i == rs2_i);
  assign is_lt  = ($signed(rs1_i) < $signed(rs2_i));
  assign is_ltu = (rs1_i < rs2_i);

  // Decode the branch condition; 010/011 are illegal and never taken.
  always_comb begin
    cond_taken = 1'b0;
    cond_legal = 1'b1;
    case (funct3_i)
      3'b000:  cond_taken = is_eq;
      3'b001:  cond_taken = ~is_eq;
      3'b100:  cond_taken = is_lt;
      3'b101:  cond_taken = ~is_lt;
      3'b110:  cond_taken = is_ltu;
      3'b111:  cond_taken = ~is_ltu;
      default: begin
        cond_taken = 1'b0;
        cond_legal = 1'b0;
      end
    endcase
  end

  assign seq_pc         = pc_i + PC_STEP;
  assign target_pc      = cond_taken ? (pc_i + imm_i) : seq_pc;
  assign accept         = valid_i & ~flush_i & cond_legal;
  assign illegal_accept = valid_i & ~flush_i & ~cond_legal;
  assign mispredict     = cond_taken ^ pred_taken_i;

  // Result registers: pulse signals clear when idle, taken/redirect hold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resolve_valid_o <= 1'b0;
      taken_o         <= 1'b0;
      mispredict_o    <= 1'b0;
      illegal_o       <= 1'b0;
      redirect_pc_o   <= {XLEN{1'b0}};
    end else if (accept) begin
      resolve_valid_o <= 1'b1;
      taken_o         <= cond_taken;
      mispredict_o    <= mispredict;
      illegal_o       <= 1'b0;
      redirect_pc_o   <= target_pc;
    end else if (illegal_accept) begin
      resolve_valid_o <= 1'b1;
      taken_o         <= 1'b0;
      mispredict_o    <= 1'b0;
      illegal_o       <= 1'b1;
      redirect_pc_o   <= seq_pc;
    end else begin
      resolve_valid_o <= 1'b0;
      mispredict_o    <= 1'b0;
      illegal_o       <= 1'b0;
    end
  end

  // Branch history table: all entries weak-not-taken on reset, trained by accepted branches.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (accept) begin
      bht[upd_idx] <= bht_next(bht[upd_idx], cond_taken);
    end else begin
      bht[upd_idx] <= bht[upd_idx];
    end
  end

  // Saturating statistics for accepted branches and their mispredicts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt_o  <= {CNT_W{1'b0}};
      mispred_cnt_o <= {CNT_W{1'b0}};
    end else if (accept) begin
      branch_cnt_o  <= cnt_inc(branch_cnt_o);
      mispred_cnt_o <= mispredict ? cnt_inc(mispred_cnt_o) : mispred_cnt_o;
    end else begin
      branch_cnt_o  <= branch_cnt_o;
      mispred_cnt_o <= mispred_cnt_o;
    end
  end

endmodule
